valu_arb: RTL and testbench
===========================

VALU_ARB -- requirements
Module: valu_arb

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 reset  in  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-003 req0_valid / req1_valid  in  1  requester n has an op pending.
REQ-004 req0_ready / req1_ready  out  1  op from requester n accepted this cycle.
REQ-005 reqN_fs  in  5  VALU function select, requester n.
REQ-006 reqN_s, reqN_t, reqN_d  in  64  operands, requester n.
REQ-007 valu_fs  out  5  to VALU FS.
REQ-008 valu_fmt  out  5  to VALU FMT; tied 5'h00.
REQ-009 valu_s, valu_t, valu_d  out  64  to VALU operands.
REQ-010 valu_y  in  64  VALU combinational result.
REQ-011 rsp_valid  out  1  result available.
REQ-012 rsp_ready  in  1  consumer takes result.
REQ-013 rsp_id  out  1  requester that issued the op (0/1).
REQ-014 rsp_y  out  64  registered result.
REQ-015 rsp_err  out  1  op used an FS code outside the legal set.
REQ-016 op_cnt  out  16  completed-response counter.

Function
REQ-017 FSM states IDLE, EXEC, RESP; one op in flight max.
REQ-018 IDLE: if any req valid, grant one, latch fs/s/t/d and id, go EXEC; else stay IDLE.
REQ-019 Grant: single valid -> that requester; both valid -> requester not granted last (round-robin via last_grant reg).
REQ-020 reqN_ready = (state==IDLE) & granted-N; combinational from valid; at most one ready high per cycle.
REQ-021 reqN_ready low in EXEC and RESP regardless of valid.
REQ-022 EXEC: valu_fs/s/t/d driven from latched regs; on cycle end capture valu_y into rsp_y, go RESP.
REQ-023 valu_* outputs hold latched values in all states (no glitch to 0 outside EXEC).
REQ-024 RESP: rsp_valid=1; rsp_y, rsp_id, rsp_err stable until handshake.
REQ-025 rsp_valid & rsp_ready -> op_cnt+1, go IDLE next cycle; no accept during RESP cycle.
REQ-026 rsp_ready low in RESP -> stay RESP indefinitely, outputs held.
REQ-027 Latency: accept at cycle N -> rsp_valid high at N+2; min issue interval 3 cycles.
REQ-028 Legal FS set {00,01,02,06,07,08,09}; others still executed (VALU passes T), rsp_err=1.
REQ-029 op_cnt wraps 16'hFFFF -> 16'h0000.
REQ-030 rsp_ready high outside RESP: ignored.
REQ-031 Requester dropping valid before grant: no effect; no op recorded.

Reset
REQ-032 Reset -> state IDLE, last_grant=1 (req0 wins first tie), rsp_valid=0, rsp_id=0, rsp_err=0, rsp_y=0, op_cnt=0, latched fs/s/t/d=0 (valu_fs=0, valu_s/t/d=0), reqN_ready=0 during reset cycle.
REQ-033 Reset in EXEC or RESP discards in-flight op; no response, op_cnt unchanged from 0.
REQ-034 Reset priority over all handshakes in same cycle.

Verification
REQ-035 req0 fs=08, s=64'h00000000000000F0, t=64'h0000000000000020 -> rsp_valid at N+2, rsp_y=64'h00000000000000FF, rsp_id=0, rsp_err=0.
REQ-036 Both valid after reset, repeated 4 ops -> grant order 0,1,0,1; rsp_id matches; op_cnt=4.
REQ-037 req1 fs=09, s_lo=3, t_lo=4, d=5 -> rsp_y[31:0]=32'd17; rsp_ready held low 5 cycles -> rsp_valid/rsp_y stable, ready signals low.
REQ-038 req0 fs=5'h1F, t=64'hDEADBEEF_01234567 -> rsp_y=t, rsp_err=1.
REQ-039 reset asserted in EXEC -> next cycle IDLE, rsp_valid=0, op_cnt=0; next op completes normally.
REQ-040 preload op_cnt via 65535 completions -> next completion op_cnt=0.

Source files
------------

// File: rtl/valu_arb.sv
// valu_arb: two-requester round-robin front end for a combinational VALU.
// Holds at most one operation in flight: IDLE (accept) -> EXEC -> RESP.
module valu_arb (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [4:0]  req0_fs,
  input  logic [63:0] req0_s,
  input  logic [63:0] req0_t,
  input  logic [63:0] req0_d,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [4:0]  req1_fs,
  input  logic [63:0] req1_s,
  input  logic [63:0] req1_t,
  input  logic [63:0] req1_d,
  output logic [4:0]  valu_fs,
  output logic [4:0]  valu_fmt,
  output logic [63:0] valu_s,
  output logic [63:0] valu_t,
  output logic [63:0] valu_d,
  input  logic [63:0] valu_y,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [63:0] rsp_y,
  output logic        rsp_err,
  output logic [15:0] op_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        last_grant;
  logic        grant0;
  logic        grant1;
  logic [4:0]  sel_fs;
  logic        sel_legal;

  // Round-robin grant: only in IDLE and never while reset is asserted.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == IDLE && !reset) begin
      if (req0_valid && req1_valid) begin
        grant0 = last_grant;
        grant1 = !last_grant;
      end else if (req0_valid) begin
        grant0 = 1'b1;
      end else if (req1_valid) begin
        grant1 = 1'b1;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // Legality of the function select of the requester being granted.
  always_comb begin
    sel_fs = grant1 ? req1_fs : req0_fs;
    unique case (sel_fs)
      5'h00, 5'h01, 5'h02, 5'h06, 5'h07, 5'h08, 5'h09: sel_legal = 1'b1;
      default:                                        sel_legal = 1'b0;
    endcase
  end

  // Next-state logic for the single-op pipeline.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (grant0 || grant1) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Operand latch, response capture, arbitration history and completion count.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= 1'b1;
      valu_fs    <= '0;
      valu_s     <= '0;
      valu_t     <= '0;
      valu_d     <= '0;
      rsp_id     <= 1'b0;
      rsp_err    <= 1'b0;
      rsp_y      <= '0;
      op_cnt     <= '0;
    end else begin
      if (grant0 || grant1) begin
        last_grant <= grant1;
        rsp_id     <= grant1;
        rsp_err    <= !sel_legal;
        valu_fs    <= sel_fs;
        valu_s     <= grant1 ? req1_s : req0_s;
        valu_t     <= grant1 ? req1_t : req0_t;
        valu_d     <= grant1 ? req1_d : req0_d;
      end
      if (state == EXEC) rsp_y <= valu_y;
      if (state == RESP && rsp_ready) op_cnt <= op_cnt + 16'd1;
    end
  end

  assign rsp_valid = (state == RESP);
  assign valu_fmt  = 5'h00;

endmodule

// File: tb/tb_valu_arb.sv
// Self-checking bench for valu_arb: directed scenarios plus randomized ops
// against a transaction-level reference (grant rule, VALU function, counter).
module tb_valu_arb;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [4:0]  req0_fs, req1_fs;
  logic [63:0] req0_s, req0_t, req0_d, req1_s, req1_t, req1_d;
  logic [4:0]  valu_fs, valu_fmt;
  logic [63:0] valu_s, valu_t, valu_d, valu_y;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [63:0] rsp_y;
  logic [15:0] op_cnt;

  int unsigned tests = 0;
  int unsigned fails = 0;

  // Reference state: who won last, and how many responses completed.
  bit          m_last = 1'b1;
  logic [15:0] m_cnt  = '0;

  valu_arb dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_fs(req0_fs),
    .req0_s(req0_s), .req0_t(req0_t), .req0_d(req0_d),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_fs(req1_fs),
    .req1_s(req1_s), .req1_t(req1_t), .req1_d(req1_d),
    .valu_fs(valu_fs), .valu_fmt(valu_fmt), .valu_s(valu_s), .valu_t(valu_t),
    .valu_d(valu_d), .valu_y(valu_y),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_y(rsp_y), .rsp_err(rsp_err), .op_cnt(op_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural VALU; unknown function codes pass T through.
  function automatic logic [63:0] valu_fn(input logic [4:0] fs, input logic [63:0] s, t, d);
    logic [31:0] mac;
    mac = s[31:0] * t[31:0] + d[31:0];
    case (fs)
      5'h00:   return s + t;
      5'h01:   return s - t;
      5'h02:   return s & t;
      5'h06:   return s | t;
      5'h07:   return s ^ t;
      5'h08:   return s | (t - 64'd1);
      5'h09:   return {32'd0, mac};
      default: return t;
    endcase
  endfunction

  function automatic bit is_legal(input logic [4:0] fs);
    return (fs <= 5'h02) || (fs >= 5'h06 && fs <= 5'h09);
  endfunction

  assign valu_y = valu_fn(valu_fs, valu_s, valu_t, valu_d);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] r64();
    return {$urandom, $urandom};
  endfunction

  // Entered at a negedge with the DUT idle; returns at the negedge after the
  // response handshake. Valids stay high through EXEC/RESP to prove ready is
  // suppressed there.
  task automatic issue(input bit v0, input bit v1,
                       input logic [4:0] f0, input logic [63:0] s0, t0, d0,
                       input logic [4:0] f1, input logic [63:0] s1, t1, d1,
                       input int hold, input bit early_ready);
    bit          g;
    logic [63:0] ey;
    logic [4:0]  efs;
    g   = (v0 && v1) ? !m_last : v1;
    efs = g ? f1 : f0;
    ey  = g ? valu_fn(f1, s1, t1, d1) : valu_fn(f0, s0, t0, d0);
    req0_valid = v0; req0_fs = f0; req0_s = s0; req0_t = t0; req0_d = d0;
    req1_valid = v1; req1_fs = f1; req1_s = s1; req1_t = t1; req1_d = d1;
    rsp_ready  = early_ready;
    #1;
    chk("ready0_grant", req0_ready, !g);
    chk("ready1_grant", req1_ready, g);
    @(posedge clk);
    m_last = g;
    @(negedge clk); #1;
    chk("exec_ready0", req0_ready, 0);
    chk("exec_ready1", req1_ready, 0);
    chk("exec_rsp_valid", rsp_valid, 0);
    chk("exec_valu_fs", valu_fs, efs);
    chk("exec_op_cnt", op_cnt, m_cnt);
    @(negedge clk); #1;
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_y", rsp_y, ey);
    chk("rsp_id", rsp_id, g);
    chk("rsp_err", rsp_err, !is_legal(efs));
    chk("resp_ready0", req0_ready, 0);
    if (hold > 0) rsp_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk); #1;
      chk("hold_rsp_valid", rsp_valid, 1);
      chk("hold_rsp_y", rsp_y, ey);
      chk("hold_ready", {req0_ready, req1_ready}, 0);
      chk("hold_valu_fs", valu_fs, efs);
    end
    rsp_ready = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk);
    m_cnt = m_cnt + 16'd1;
    @(negedge clk); #1;
    chk("post_rsp_valid", rsp_valid, 0);
    chk("op_cnt", op_cnt, m_cnt);
    rsp_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    chk("reset_ready", {req0_ready, req1_ready}, 0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    m_last = 1'b1; m_cnt = '0;
    #1;
  endtask

  initial begin
    reset = 1'b1; rsp_ready = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_fs = '0; req0_s = '0; req0_t = '0; req0_d = '0;
    req1_fs = '0; req1_s = '0; req1_t = '0; req1_d = '0;
    @(negedge clk);
    do_reset();
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_rsp_y", rsp_y, 0);
    chk("rst_op_cnt", op_cnt, 0);
    chk("rst_valu", {valu_fs, valu_fmt, valu_s, valu_t, valu_d}, 0);
    chk("rst_valu_d", valu_d, 0);

    // Single requester, fs=08.
    issue(1, 0, 5'h08, 64'hF0, 64'h20, 64'h0, 5'h00, 64'h0, 64'h0, 64'h0, 0, 0);
    chk("fs08_value", rsp_y, 64'hFF);

    // Fresh reset, both requesters always valid: order 0,1,0,1.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      issue(1, 1, 5'h00, r64(), r64(), r64(), 5'h07, r64(), r64(), r64(), 0, 0);
      chk("rr_order", rsp_id, i % 2);
    end
    chk("rr_op_cnt4", op_cnt, 16'd4);

    // Multiply-add with consumer back-pressure for 5 cycles.
    issue(0, 1, 5'h00, 64'h0, 64'h0, 64'h0, 5'h09, 64'd3, 64'd4, 64'd5, 5, 0);
    chk("mac_value", rsp_y[31:0], 32'd17);

    // Illegal function code passes T and flags an error.
    issue(1, 0, 5'h1F, r64(), 64'hDEADBEEF_01234567, r64(), 5'h00, 64'h0, 64'h0, 64'h0, 0, 1);
    chk("illegal_y", rsp_y, 64'hDEADBEEF_01234567);
    chk("illegal_err", rsp_err, 1);

    // Reset while an op is executing discards it.
    req0_valid = 1'b1; req0_fs = 5'h06; req0_s = 64'h1234; req0_t = 64'h5678;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1; req0_valid = 1'b0;
    #1;
    chk("rst_exec_ready", {req0_ready, req1_ready}, 0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0; m_last = 1'b1; m_cnt = '0;
    #1;
    chk("rst_exec_rsp_valid", rsp_valid, 0);
    chk("rst_exec_op_cnt", op_cnt, 0);
    chk("rst_exec_valu_s", valu_s, 0);
    @(negedge clk); #1;
    chk("rst_exec_stays_idle", rsp_valid, 0);
    issue(1, 1, 5'h01, r64(), r64(), r64(), 5'h02, r64(), r64(), r64(), 0, 0);

    // Randomized traffic, including unknown function codes.
    for (int n = 0; n < 30; n++) begin
      bit v0, v1;
      int h;
      v0 = $urandom_range(0, 1);
      v1 = v0 ? $urandom_range(0, 1) : 1'b1;
      h  = $urandom_range(0, 3);
      issue(v0, v1, 5'($urandom_range(0, 31)), r64(), r64(), r64(),
            5'($urandom_range(0, 31)), r64(), r64(), r64(), h, (h == 0) && $urandom_range(0, 1));
    end

    // Counter wrap: preload to all-ones, then one more completion.
    force dut.op_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.op_cnt;
    m_cnt = 16'hFFFF;
    #1;
    chk("preload_op_cnt", op_cnt, 16'hFFFF);
    issue(0, 1, 5'h00, 64'h0, 64'h0, 64'h0, 5'h00, 64'd1, 64'd2, 64'd0, 0, 0);
    chk("wrap_op_cnt", op_cnt, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
